// File: rtl/dac_seq_pkg.sv
// dac_seq_pkg: shared widths and state encoding for dac_out_sequencer
package dac_seq_pkg;
    localparam int DAC_DW = 24;
    localparam int PRIME_W = 4;
    localparam int UR_W = 8;
    localparam int UR_CNT_W = 8;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t PRIME = 2'd1;
    localparam state_t RUN_R = 2'd2;
    localparam state_t RUN_L = 2'd3;
endpackage

// File: rtl/dac_out_sequencer_sat_counter.sv
// sat_counter: saturating up-counter; inc with clr together loads 1 so a set beats a clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         pclk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    always_ff @(posedge pclk)
        if (!rst_n) q <= '0;
        else if (inc) q <= clr ? W'(1) : (&q ? q : q + 1'b1);
        else if (clr) q <= '0;
endmodule

// File: rtl/dac_out_sequencer.sv
// dac_out_sequencer: paces stereo FIFO frames onto the DAC word bus, left then right per frame
// DAC_OUT_SEQ_UNDERRUN_CNT_EN builds the saturating underrun_cnt; otherwise it reads 0.
module dac_out_sequencer
    import dac_seq_pkg::*;
#(
    parameter int DW = DAC_DW,
    parameter int START_DELAY = 2,
    parameter int MAX_UNDERRUN = 4
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                outclk,
    input  logic                fifo_empty,
    input  logic [2*DW-1:0]     fifo_rdata,
    output logic                fifo_ren,
    input  logic                mute,
    input  logic                underrun_clr,
    output logic [DW-1:0]       dout,
    output logic                dout_ch,
    output logic                dout_en,
    output logic                underrun,
    output logic [UR_CNT_W-1:0] underrun_cnt
);
    state_t              state;
    logic [2*DW-1:0]     frame_q;
    logic [PRIME_W-1:0]  prime_cnt;
    logic [UR_W-1:0]     ur_cnt;
    logic                prime_done, capture, ur_evt, ur_last, prime_inc, prime_clr;
    always_comb begin
        prime_done = prime_cnt == PRIME_W'(START_DELAY);
        capture    = outclk && !fifo_empty && (state == RUN_L || (state == PRIME && prime_done));
        ur_evt     = outclk && fifo_empty && state == RUN_L;
        ur_last    = ur_evt && ur_cnt == UR_W'(MAX_UNDERRUN - 1);
        fifo_ren   = rst_n && capture;
        prime_inc  = outclk && !fifo_empty && (state == IDLE || (state == PRIME && !prime_done));
        prime_clr  = outclk && (state == IDLE || (state == PRIME && (fifo_empty || prime_done)));
    end
    sat_counter #(.W(PRIME_W)) u_prime_cnt (
        .pclk(pclk), .rst_n(rst_n), .inc(prime_inc), .clr(prime_clr), .q(prime_cnt)
    );
    sat_counter #(.W(UR_W)) u_ur_cnt (
        .pclk(pclk), .rst_n(rst_n), .inc(ur_evt), .clr(capture), .q(ur_cnt)
    );
`ifdef DAC_OUT_SEQ_UNDERRUN_CNT_EN
    sat_counter #(.W(UR_CNT_W)) u_underrun_cnt (
        .pclk(pclk), .rst_n(rst_n), .inc(ur_evt), .clr(underrun_clr), .q(underrun_cnt)
    );
`else
    assign underrun_cnt = '0;
`endif
    always_ff @(posedge pclk)
        if (!rst_n) begin
            state    <= IDLE;
            frame_q  <= '0;
            dout     <= '0;
            dout_ch  <= 1'b0;
            dout_en  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (ur_evt || underrun_clr) underrun <= ur_evt;
            if (capture) begin
                frame_q <= fifo_rdata;
                dout    <= mute ? '0 : fifo_rdata[2*DW-1:DW];
                dout_ch <= 1'b0;
                dout_en <= 1'b1;
                state   <= RUN_R;
            end else if (ur_evt) begin
                // zero frame keeps channel alignment; the right slot replays the cleared frame_q
                frame_q <= '0;
                dout    <= '0;
                dout_ch <= 1'b0;
                dout_en <= !ur_last;
                state   <= ur_last ? IDLE : RUN_R;
            end else if (outclk) begin
                case (state)
                    IDLE: begin
                        dout_en <= 1'b0;
                        state   <= fifo_empty ? IDLE : PRIME;
                    end
                    PRIME: state <= fifo_empty ? IDLE : PRIME;
                    RUN_R: begin
                        dout    <= mute ? '0 : frame_q[DW-1:0];
                        dout_ch <= 1'b1;
                        state   <= RUN_L;
                    end
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_dac_out_sequencer.sv
// tb_dac_out_sequencer: FIFO model plus expected-word scoreboard for dac_out_sequencer
module tb_dac_out_sequencer;
`ifdef DAC_OUT_SEQ_UNDERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic        pclk = 1'b0, rst_n = 1'b0, outclk = 1'b0, fifo_empty = 1'b1;
    logic [47:0] fifo_rdata = '0;
    logic        mute = 1'b0, underrun_clr = 1'b0;
    logic        fifo_ren, dout_ch, dout_en, underrun;
    logic [23:0] dout;
    logic [7:0]  underrun_cnt;
    logic [47:0] fifo_q[$];
    logic [24:0] sb[$];
    int          ren_log[$];
    int          checks = 0, errors = 0, sidx = 0, ren_total = 0, gap = 8, r0;

    dac_out_sequencer #(.DW(24), .START_DELAY(2), .MAX_UNDERRUN(4)) dut (
        .pclk(pclk), .rst_n(rst_n), .outclk(outclk), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren), .mute(mute),
        .underrun_clr(underrun_clr), .dout(dout), .dout_ch(dout_ch), .dout_en(dout_en),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 pclk = ~pclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fifo_upd();
        fifo_empty = fifo_q.size() == 0;
        fifo_rdata = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
        fifo_q.push_back({l, r});
        fifo_upd();
    endtask

    task automatic exp_frame(input logic [23:0] l, input logic [23:0] r);
        sb.push_back({1'b0, l});
        sb.push_back({1'b1, r});
    endtask

    task automatic strobe(input bit clr = 1'b0);
        logic        ren;
        logic [24:0] e;
        @(negedge pclk);
        outclk = 1'b1;
        underrun_clr = clr;
        #1;
        ren = fifo_ren;
        sidx++;
        if (ren) begin
            ren_total++;
            ren_log.push_back(sidx);
            check("pop_nonempty", 48'(fifo_empty), 48'(0));
        end
        @(posedge pclk);
        #1;
        outclk = 1'b0;
        underrun_clr = 1'b0;
        if (ren && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            fifo_upd();
        end
        if (dout_en) begin
            e = sb.size() > 0 ? sb.pop_front() : 25'h1ffffff;
            check("dout_word", 48'({dout_ch, dout}), 48'(e));
        end
        repeat (gap - 2) @(posedge pclk);
    endtask

    // k underrun frames already seen; runs the rest through the final strobe back to IDLE
    task automatic drain(input int k);
        int n;
        n = 4 - k;
        repeat (n - 1) exp_frame(24'h0, 24'h0);
        repeat (2 * n - 1) strobe();
    endtask

    task automatic clr_ur();
        @(negedge pclk);
        underrun_clr = 1'b1;
        @(negedge pclk);
        underrun_clr = 1'b0;
        check("clr_flag", 48'(underrun), 48'(0));
        check("clr_cnt", 48'(underrun_cnt), 48'(0));
    endtask

    initial begin
        fifo_upd();
        repeat (3) @(posedge pclk);
        #1;
        check("rst_dout", 48'(dout), 48'(0));
        check("rst_ch", 48'(dout_ch), 48'(0));
        check("rst_en", 48'(dout_en), 48'(0));
        check("rst_ur", 48'(underrun), 48'(0));
        check("rst_cnt", 48'(underrun_cnt), 48'(0));
        @(negedge pclk);
        rst_n = 1'b1;

        push_frame(24'hAAAAAA, 24'h111111);
        push_frame(24'hBBBBBB, 24'h222222);
        exp_frame(24'hAAAAAA, 24'h111111);
        exp_frame(24'hBBBBBB, 24'h222222);
        sidx = 0;
        ren_log.delete();
        repeat (6) strobe();
        check("ren_count", 48'(ren_log.size()), 48'(2));
        check("ren_at_0", 48'(ren_log.size() > 0 ? ren_log[0] : 0), 48'(3));
        check("ren_at_1", 48'(ren_log.size() > 1 ? ren_log[1] : 0), 48'(5));
        drain(0);
        check("ur_flag", 48'(underrun), 48'(1));
        check("ur_cnt4", 48'(underrun_cnt), 48'(CNT_EN ? 4 : 0));
        check("ur_idle_en", 48'(dout_en), 48'(0));
        clr_ur();

        push_frame(24'h333333, 24'h444444);
        exp_frame(24'h333333, 24'h444444);
        exp_frame(24'h0, 24'h0);
        repeat (5) strobe();
        push_frame(24'h555555, 24'h666666);
        exp_frame(24'h555555, 24'h666666);
        repeat (3) strobe();
        drain(0);
        check("refill_cnt", 48'(underrun_cnt), 48'(CNT_EN ? 5 : 0));
        clr_ur();

        r0 = ren_total;
        push_frame(24'h777777, 24'h888888);
        strobe();
        fifo_q.delete();
        fifo_upd();
        strobe();
        check("abort_ren", 48'(ren_total), 48'(r0));
        check("abort_en", 48'(dout_en), 48'(0));
        push_frame(24'h777777, 24'h888888);
        exp_frame(24'h777777, 24'h888888);
        sidx = 0;
        ren_log.delete();
        repeat (4) strobe();
        check("reprime_ren", 48'(ren_log.size()), 48'(1));
        check("reprime_at", 48'(ren_log.size() > 0 ? ren_log[0] : 0), 48'(3));
        drain(0);
        clr_ur();

        push_frame(24'h010101, 24'h020202);
        push_frame(24'h030303, 24'h040404);
        push_frame(24'h050505, 24'h060606);
        push_frame(24'h070707, 24'h080808);
        exp_frame(24'h0, 24'h0);
        exp_frame(24'h0, 24'h0);
        exp_frame(24'h0, 24'h060606);
        exp_frame(24'h070707, 24'h080808);
        r0 = ren_total;
        mute = 1'b1;
        repeat (7) strobe();
        mute = 1'b0;
        repeat (3) strobe();
        check("mute_ren", 48'(ren_total - r0), 48'(4));
        drain(0);
        clr_ur();

        push_frame(24'h0A0A0A, 24'h0B0B0B);
        exp_frame(24'h0A0A0A, 24'h0B0B0B);
        repeat (4) strobe();
        exp_frame(24'h0, 24'h0);
        strobe(1'b1);
        check("race_flag", 48'(underrun), 48'(1));
        check("race_cnt", 48'(underrun_cnt), 48'(CNT_EN ? 1 : 0));
        strobe();
        drain(1);

`ifdef DAC_OUT_SEQ_UNDERRUN_CNT_EN
        clr_ur();
        gap = 3;
        for (int i = 0; i < 75; i++) begin
            push_frame(24'(i), 24'(i + 1000));
            exp_frame(24'(i), 24'(i + 1000));
            repeat (4) strobe();
            drain(0);
        end
        gap = 8;
        check("sat_cnt", 48'(underrun_cnt), 48'(255));
`endif

        push_frame(24'h0C0C0C, 24'h0D0D0D);
        push_frame(24'h0E0E0E, 24'h0F0F0F);
        exp_frame(24'h0C0C0C, 24'h0D0D0D);
        repeat (4) strobe();
        @(negedge pclk);
        outclk = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_ren", 48'(fifo_ren), 48'(0));
        @(posedge pclk);
        #1;
        outclk = 1'b0;
        check("mid_rst_dout", 48'(dout), 48'(0));
        check("mid_rst_ch", 48'(dout_ch), 48'(0));
        check("mid_rst_en", 48'(dout_en), 48'(0));
        check("mid_rst_ur", 48'(underrun), 48'(0));
        check("mid_rst_cnt", 48'(underrun_cnt), 48'(0));
        fifo_q.delete();
        fifo_upd();
        @(negedge pclk);
        rst_n = 1'b1;
        check("sb_drained", 48'(sb.size()), 48'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
